// File: rtl/cpu_pkg.sv
// Shared CPU encodings: opcodes, sequencer states and datapath control codes.
// Also defines the control-word struct that the sequencer produces each cycle.
package cpu_pkg;

   typedef enum logic [2:0] {
      S_FETCH_L,
      S_FETCH_H,
      S_EXEC1,
      S_EXEC2,
      S_HALT
   } state_t;

   localparam logic [3:0] OP_NOP  = 4'h0;
   localparam logic [3:0] OP_BRA  = 4'h1;
   localparam logic [3:0] OP_MOVI = 4'h2;
   localparam logic [3:0] OP_ADD  = 4'h3;
   localparam logic [3:0] OP_SUB  = 4'h4;
   localparam logic [3:0] OP_AND  = 4'h5;
   localparam logic [3:0] OP_LD   = 4'h6;
   localparam logic [3:0] OP_ST   = 4'h7;
   localparam logic [3:0] OP_BEQ  = 4'h8;
   localparam logic [3:0] OP_HALT = 4'hF;

   localparam logic [3:0] REG_NONE = 4'b0000;
   localparam logic [3:0] REG_R1   = 4'b1000;
   localparam logic [3:0] REG_R2   = 4'b0100;
   localparam logic [3:0] REG_R3   = 4'b0010;
   localparam logic [3:0] REG_R4   = 4'b0001;

   localparam logic [2:0] RF_FUN_DEC  = 3'd0;
   localparam logic [2:0] RF_FUN_INC  = 3'd1;
   localparam logic [2:0] RF_FUN_LOAD = 3'd2;
   localparam logic [2:0] RF_FUN_CLR  = 3'd3;

   localparam logic [2:0] ARF_SEL_NONE = 3'b000;
   localparam logic [2:0] ARF_SEL_PC   = 3'b100;
   localparam logic [2:0] ARF_SEL_AR   = 3'b010;
   localparam logic [2:0] ARF_SEL_SP   = 3'b001;

   localparam logic [1:0] ARF_OUT_PC = 2'd0;
   localparam logic [1:0] ARF_OUT_SP = 2'd1;
   localparam logic [1:0] ARF_OUT_AR = 2'd2;

   localparam logic [1:0] ARF_FUN_DEC  = 2'd0;
   localparam logic [1:0] ARF_FUN_INC  = 2'd1;
   localparam logic [1:0] ARF_FUN_LOAD = 2'd2;
   localparam logic [1:0] ARF_FUN_CLR  = 2'd3;

   localparam logic [4:0] ALU_PASSA = 5'h00;
   localparam logic [4:0] ALU_ADD   = 5'h04;
   localparam logic [4:0] ALU_SUB   = 5'h06;
   localparam logic [4:0] ALU_AND   = 5'h07;

   localparam logic [1:0] MUXA_ALU = 2'd0;
   localparam logic [1:0] MUXA_ARF = 2'd1;
   localparam logic [1:0] MUXA_DR  = 2'd2;
   localparam logic [1:0] MUXA_IR  = 2'd3;

   localparam logic [1:0] MUXB_ALU = 2'd0;
   localparam logic [1:0] MUXB_ARF = 2'd1;
   localparam logic [1:0] MUXB_DR  = 2'd2;
   localparam logic [1:0] MUXB_IR  = 2'd3;

   localparam logic [1:0] MUXC_ALU_LO = 2'd0;

   localparam logic [1:0] DR_FUN_CLR  = 2'd0;
   localparam logic [1:0] DR_FUN_LOAD = 2'd1;

   typedef struct packed {
      logic [2:0] rf_outasel;
      logic [2:0] rf_outbsel;
      logic [2:0] rf_funsel;
      logic [3:0] rf_regsel;
      logic [3:0] rf_scrsel;
      logic [4:0] alu_funsel;
      logic       alu_wf;
      logic [1:0] arf_outcsel;
      logic [1:0] arf_outdsel;
      logic [1:0] arf_funsel;
      logic [2:0] arf_regsel;
      logic       ir_lh;
      logic       ir_write;
      logic       mem_wr;
      logic       mem_cs;
      logic [1:0] mux_asel;
      logic [1:0] mux_bsel;
      logic [1:0] mux_csel;
      logic [1:0] dr_funsel;
      logic       dr_e;
      logic       mux_dsel;
   } ctrl_t;

   function automatic ctrl_t idle_ctrl();
      ctrl_t c;
      c        = '0;
      c.mem_cs = 1'b1;
      return c;
   endfunction

   function automatic logic [3:0] reg_onehot(input logic [1:0] idx);
      logic [3:0] sel;
      case (idx)
         2'd0:    sel = REG_R1;
         2'd1:    sel = REG_R2;
         2'd2:    sel = REG_R3;
         default: sel = REG_R4;
      endcase
      return sel;
   endfunction

   function automatic logic [4:0] alu_fun_for(input logic [3:0] op);
      logic [4:0] f;
      case (op)
         OP_SUB:  f = ALU_SUB;
         OP_AND:  f = ALU_AND;
         default: f = ALU_ADD;
      endcase
      return f;
   endfunction

endpackage

// File: rtl/control_sequencer_if.sv
// Bundle between the control sequencer and the datapath: instruction/flags in,
// control word, sequence count and halt status out.
interface control_sequencer_if;
   logic [15:0] IROut;
   logic [3:0]  Flags;
   logic [2:0]  RF_OutASel;
   logic [2:0]  RF_OutBSel;
   logic [2:0]  RF_FunSel;
   logic [3:0]  RF_RegSel;
   logic [3:0]  RF_ScrSel;
   logic [4:0]  ALU_FunSel;
   logic        ALU_WF;
   logic [1:0]  ARF_OutCSel;
   logic [1:0]  ARF_OutDSel;
   logic [1:0]  ARF_FunSel;
   logic [2:0]  ARF_RegSel;
   logic        IR_LH;
   logic        IR_Write;
   logic        Mem_WR;
   logic        Mem_CS;
   logic [1:0]  MuxASel;
   logic [1:0]  MuxBSel;
   logic [1:0]  MuxCSel;
   logic [1:0]  DR_FunSel;
   logic        DR_E;
   logic        MuxDSel;
   logic [2:0]  T;
   logic        Halted;

   modport master (
      input  IROut, Flags,
      output RF_OutASel, RF_OutBSel, RF_FunSel, RF_RegSel, RF_ScrSel,
             ALU_FunSel, ALU_WF, ARF_OutCSel, ARF_OutDSel, ARF_FunSel,
             ARF_RegSel, IR_LH, IR_Write, Mem_WR, Mem_CS, MuxASel, MuxBSel,
             MuxCSel, DR_FunSel, DR_E, MuxDSel, T, Halted
   );

   modport slave (
      output IROut, Flags,
      input  RF_OutASel, RF_OutBSel, RF_FunSel, RF_RegSel, RF_ScrSel,
             ALU_FunSel, ALU_WF, ARF_OutCSel, ARF_OutDSel, ARF_FunSel,
             ARF_RegSel, IR_LH, IR_Write, Mem_WR, Mem_CS, MuxASel, MuxBSel,
             MuxCSel, DR_FunSel, DR_E, MuxDSel, T, Halted
   );
endinterface

// File: rtl/sequence_counter.sv
// 3-bit timing counter for the sequencer: clear, load-7 (halt marker) or increment.
module sequence_counter (
   input  logic       i_clk,
   input  logic       i_rst,
   input  logic       i_clr,
   input  logic       i_load7,
   input  logic       i_inc,
   output logic [2:0] o_count
);

   logic [2:0] r_count;

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst)        r_count <= '0;
      else if (i_clr)   r_count <= '0;
      else if (i_load7) r_count <= 3'd7;
      else if (i_inc)   r_count <= r_count + 3'd1;
   end

   assign o_count = r_count;

endmodule

// File: rtl/control_sequencer.sv
// Moore control sequencer: two-byte fetch, one or two execute steps, sticky HALT.
// Outputs depend on the state and IROut only (Flags enters solely through BEQ).
module control_sequencer
   import cpu_pkg::*;
(
   input logic                 Clock,
   input logic                 Reset,
   control_sequencer_if.master bus
);

   state_t     r_state;
   state_t     w_next;
   ctrl_t      w_ctrl;
   logic [3:0] w_op;
   logic [1:0] w_rd;
   logic [1:0] w_rs;
   logic       w_cnt_clr;
   logic       w_cnt_load7;
   logic       w_cnt_inc;
   logic       w_unused_bits;

   assign w_op          = bus.IROut[15:12];
   assign w_rd          = bus.IROut[11:10];
   assign w_rs          = bus.IROut[9:8];
   assign w_unused_bits = ^{bus.IROut[7:0], bus.Flags[2:0]};

   always_ff @(posedge Clock or posedge Reset) begin
      if (Reset) r_state <= S_FETCH_L;
      else       r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         S_FETCH_L: w_next = S_FETCH_H;
         S_FETCH_H: w_next = S_EXEC1;
         S_EXEC1: begin
            if (w_op == OP_LD)        w_next = S_EXEC2;
            else if (w_op == OP_HALT) w_next = S_HALT;
            else                      w_next = S_FETCH_L;
         end
         S_EXEC2:   w_next = S_FETCH_L;
         S_HALT:    w_next = S_HALT;
         default:   w_next = S_FETCH_L;
      endcase
   end

   // T tracks the state, so the counter is steered from the next state
   assign w_cnt_clr   = (w_next == S_FETCH_L);
   assign w_cnt_load7 = (w_next == S_HALT);
   assign w_cnt_inc   = !w_cnt_clr && !w_cnt_load7;

   sequence_counter u_seq_cnt (
      .i_clk   (Clock),
      .i_rst   (Reset),
      .i_clr   (w_cnt_clr),
      .i_load7 (w_cnt_load7),
      .i_inc   (w_cnt_inc),
      .o_count (bus.T)
   );

   always_comb begin
      w_ctrl = idle_ctrl();
      if (!Reset) begin
         case (r_state)
            S_FETCH_L, S_FETCH_H: begin
               w_ctrl.arf_outdsel = ARF_OUT_PC;
               w_ctrl.mem_cs      = 1'b0;
               w_ctrl.mem_wr      = 1'b0;
               w_ctrl.ir_write    = 1'b1;
               w_ctrl.ir_lh       = (r_state == S_FETCH_H);
               w_ctrl.arf_regsel  = ARF_SEL_PC;
               w_ctrl.arf_funsel  = ARF_FUN_INC;
            end
            S_EXEC1: begin
               case (w_op)
                  OP_BRA, OP_BEQ: begin
                     if (w_op == OP_BRA || bus.Flags[3]) begin
                        w_ctrl.mux_bsel   = MUXB_IR;
                        w_ctrl.arf_regsel = ARF_SEL_PC;
                        w_ctrl.arf_funsel = ARF_FUN_LOAD;
                     end
                  end
                  OP_MOVI: begin
                     w_ctrl.mux_asel  = MUXA_IR;
                     w_ctrl.rf_regsel = reg_onehot(w_rd);
                     w_ctrl.rf_funsel = RF_FUN_LOAD;
                  end
                  OP_ADD, OP_SUB, OP_AND: begin
                     w_ctrl.rf_outasel = {1'b0, w_rd};
                     w_ctrl.rf_outbsel = {1'b0, w_rs};
                     w_ctrl.mux_dsel   = 1'b0;
                     w_ctrl.alu_funsel = alu_fun_for(w_op);
                     w_ctrl.alu_wf     = 1'b1;
                     w_ctrl.mux_asel   = MUXA_ALU;
                     w_ctrl.rf_regsel  = reg_onehot(w_rd);
                     w_ctrl.rf_funsel  = RF_FUN_LOAD;
                  end
                  OP_LD: begin
                     w_ctrl.arf_outdsel = ARF_OUT_AR;
                     w_ctrl.mem_cs      = 1'b0;
                     w_ctrl.dr_e        = 1'b1;
                     w_ctrl.dr_funsel   = DR_FUN_LOAD;
                  end
                  OP_ST: begin
                     w_ctrl.rf_outasel  = {1'b0, w_rd};
                     w_ctrl.alu_funsel  = ALU_PASSA;
                     w_ctrl.mux_csel    = MUXC_ALU_LO;
                     w_ctrl.arf_outdsel = ARF_OUT_AR;
                     w_ctrl.mem_cs      = 1'b0;
                     w_ctrl.mem_wr      = 1'b1;
                  end
                  default: ;
               endcase
            end
            S_EXEC2: begin
               w_ctrl.mux_asel  = MUXA_DR;
               w_ctrl.rf_regsel = reg_onehot(w_rd);
               w_ctrl.rf_funsel = RF_FUN_LOAD;
            end
            default: ;
         endcase
      end
   end

   assign bus.RF_OutASel  = w_ctrl.rf_outasel;
   assign bus.RF_OutBSel  = w_ctrl.rf_outbsel;
   assign bus.RF_FunSel   = w_ctrl.rf_funsel;
   assign bus.RF_RegSel   = w_ctrl.rf_regsel;
   assign bus.RF_ScrSel   = w_ctrl.rf_scrsel;
   assign bus.ALU_FunSel  = w_ctrl.alu_funsel;
   assign bus.ALU_WF      = w_ctrl.alu_wf;
   assign bus.ARF_OutCSel = w_ctrl.arf_outcsel;
   assign bus.ARF_OutDSel = w_ctrl.arf_outdsel;
   assign bus.ARF_FunSel  = w_ctrl.arf_funsel;
   assign bus.ARF_RegSel  = w_ctrl.arf_regsel;
   assign bus.IR_LH       = w_ctrl.ir_lh;
   assign bus.IR_Write    = w_ctrl.ir_write;
   assign bus.Mem_WR      = w_ctrl.mem_wr;
   assign bus.Mem_CS      = w_ctrl.mem_cs;
   assign bus.MuxASel     = w_ctrl.mux_asel;
   assign bus.MuxBSel     = w_ctrl.mux_bsel;
   assign bus.MuxCSel     = w_ctrl.mux_csel;
   assign bus.DR_FunSel   = w_ctrl.dr_funsel;
   assign bus.DR_E        = w_ctrl.dr_e;
   assign bus.MuxDSel     = w_ctrl.mux_dsel;
   assign bus.Halted      = (r_state == S_HALT);

endmodule

// File: tb/tb_control_sequencer.sv
// Bench for control_sequencer: directed and random instruction streams compared
// against a per-instruction behavioural model of the control word, T and Halted.
module tb_control_sequencer;
   import cpu_pkg::*;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   int unsigned n_checks = 0;
   int unsigned n_pass   = 0;

   control_sequencer_if ifc ();

   control_sequencer dut (
      .Clock (clk),
      .Reset (rst),
      .bus   (ifc)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [2:0] rf_outasel;
      logic [2:0] rf_outbsel;
      logic [2:0] rf_funsel;
      logic [3:0] rf_regsel;
      logic [3:0] rf_scrsel;
      logic [4:0] alu_funsel;
      logic       alu_wf;
      logic [1:0] arf_outcsel;
      logic [1:0] arf_outdsel;
      logic [1:0] arf_funsel;
      logic [2:0] arf_regsel;
      logic       ir_lh;
      logic       ir_write;
      logic       mem_wr;
      logic       mem_cs;
      logic [1:0] mux_asel;
      logic [1:0] mux_bsel;
      logic [1:0] mux_csel;
      logic [1:0] dr_funsel;
      logic       dr_e;
      logic       mux_dsel;
      logic [2:0] t;
      logic       halted;
   } exp_t;

   // phase: 0/1 fetch bytes, 2 first execute step, 3 LD write-back, 7 halted
   function automatic exp_t model(input int phase, input logic [15:0] ir,
                                  input logic [3:0] fl, input logic in_rst);
      exp_t       e;
      logic [3:0] op;
      logic [1:0] rd;
      logic [1:0] rs;
      logic [3:0] rd_hot;
      op     = ir[15:12];
      rd     = ir[11:10];
      rs     = ir[9:8];
      rd_hot = 4'b1000 >> rd;
      e        = '0;
      e.mem_cs = 1'b1;
      if (in_rst) return e;
      e.t = 3'(phase);
      if (phase == 7) begin
         e.halted = 1'b1;
         return e;
      end
      if (phase < 2) begin
         e.arf_outdsel = ARF_OUT_PC;
         e.mem_cs      = 1'b0;
         e.ir_write    = 1'b1;
         e.ir_lh       = (phase == 1);
         e.arf_regsel  = ARF_SEL_PC;
         e.arf_funsel  = ARF_FUN_INC;
         return e;
      end
      if (phase == 3) begin
         e.mux_asel  = MUXA_DR;
         e.rf_regsel = rd_hot;
         e.rf_funsel = RF_FUN_LOAD;
         return e;
      end
      if (op == OP_BRA || (op == OP_BEQ && fl[3])) begin
         e.mux_bsel   = MUXB_IR;
         e.arf_regsel = ARF_SEL_PC;
         e.arf_funsel = ARF_FUN_LOAD;
      end else if (op == OP_MOVI) begin
         e.mux_asel  = MUXA_IR;
         e.rf_regsel = rd_hot;
         e.rf_funsel = RF_FUN_LOAD;
      end else if (op >= OP_ADD && op <= OP_AND) begin
         e.rf_outasel = {1'b0, rd};
         e.rf_outbsel = {1'b0, rs};
         e.alu_funsel = (op == OP_ADD) ? ALU_ADD : (op == OP_SUB) ? ALU_SUB : ALU_AND;
         e.alu_wf     = 1'b1;
         e.mux_asel   = MUXA_ALU;
         e.rf_regsel  = rd_hot;
         e.rf_funsel  = RF_FUN_LOAD;
      end else if (op == OP_LD) begin
         e.arf_outdsel = ARF_OUT_AR;
         e.mem_cs      = 1'b0;
         e.dr_e        = 1'b1;
         e.dr_funsel   = DR_FUN_LOAD;
      end else if (op == OP_ST) begin
         e.rf_outasel  = {1'b0, rd};
         e.alu_funsel  = ALU_PASSA;
         e.arf_outdsel = ARF_OUT_AR;
         e.mem_cs      = 1'b0;
         e.mem_wr      = 1'b1;
      end
      return e;
   endfunction

   task automatic check_vec(input string tag, input exp_t e);
      exp_t o;
      o = {ifc.RF_OutASel, ifc.RF_OutBSel, ifc.RF_FunSel, ifc.RF_RegSel,
           ifc.RF_ScrSel, ifc.ALU_FunSel, ifc.ALU_WF, ifc.ARF_OutCSel,
           ifc.ARF_OutDSel, ifc.ARF_FunSel, ifc.ARF_RegSel, ifc.IR_LH,
           ifc.IR_Write, ifc.Mem_WR, ifc.Mem_CS, ifc.MuxASel, ifc.MuxBSel,
           ifc.MuxCSel, ifc.DR_FunSel, ifc.DR_E, ifc.MuxDSel, ifc.T, ifc.Halted};
      n_checks++;
      assert (o === e) n_pass++;
      else $error("FAIL %s: observed %h expected %h (T obs %0d exp %0d)",
                  tag, o, e, o.t, e.t);
   endtask

   task automatic step(input string tag, input int phase, input logic [15:0] ir,
                       input logic [3:0] fl, input logic r);
      @(negedge clk);
      rst       = r;
      ifc.IROut = ir;
      ifc.Flags = fl;
      #1;
      check_vec(tag, model(phase, ir, fl, r));
   endtask

   task automatic run_instr(input string tag, input logic [15:0] ir, input logic [3:0] fl);
      step(tag, 0, 16'($urandom), 4'($urandom), 1'b0);
      step(tag, 1, 16'($urandom), 4'($urandom), 1'b0);
      step(tag, 2, ir, fl, 1'b0);
      if (ir[15:12] == OP_LD) step(tag, 3, ir, fl, 1'b0);
   endtask

   initial begin
      logic [15:0] ir;
      ifc.IROut = '0;
      ifc.Flags = '0;

      step("reset", 0, 16'h7000, 4'hF, 1'b1);
      step("reset", 0, 16'hF000, 4'h0, 1'b1);

      run_instr("nop",    16'h0000, 4'h0);
      run_instr("movi",   16'h2A5C, 4'h0);
      run_instr("ld",     16'h6400, 4'h0);
      run_instr("beq_t",  16'h8010, 4'b1000);
      run_instr("beq_nt", 16'h8010, 4'b0000);
      run_instr("bra",    16'h1033, 4'b0000);
      run_instr("add",    16'h3D00, 4'h5);
      run_instr("sub",    16'h4700, 4'hA);
      run_instr("and",    16'h5E00, 4'h3);
      run_instr("st",     16'h7900, 4'h8);
      run_instr("undef9", 16'h9ABC, 4'hF);
      run_instr("undefE", 16'hE123, 4'hF);

      for (int i = 0; i < 40; i++) begin
         ir = {4'($urandom_range(0, 14)), 12'($urandom)};
         run_instr("rand", ir, 4'($urandom));
      end

      step("st_abort", 0, 16'h1234, 4'h0, 1'b0);
      step("st_abort", 1, 16'h4321, 4'h0, 1'b0);
      step("st_abort", 2, 16'h7B00, 4'h0, 1'b0);
      rst = 1'b1;
      #1;
      check_vec("st_abort_rst", model(0, 16'h7B00, 4'h0, 1'b1));
      n_checks++;
      assert (ifc.Mem_WR === 1'b0) n_pass++;
      else $error("FAIL st_abort_memwr: observed %b expected 0", ifc.Mem_WR);
      step("st_abort_hold", 0, 16'h7B00, 4'h0, 1'b1);
      run_instr("post_abort", 16'h2000, 4'h0);

      run_instr("halt", 16'hF000, 4'h0);
      for (int i = 0; i < 20; i++)
         step("halt_hold", 7, 16'($urandom), 4'($urandom), 1'b0);
      step("halt_rst", 0, 16'hF000, 4'h0, 1'b1);
      run_instr("post_halt", 16'h3500, 4'h0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/control_sequencer.md
CONTROL_SEQUENCER -- requirements
Module: control_sequencer

Interface
REQ-001 SHALL have parameters: none; all encodings come from package constants.
REQ-002 SHALL have ports `Clock` (input, 1, sole clock, rising edge) and `Reset` (input, 1, asynchronous, active-high).
REQ-003 SHALL have inputs `IROut` (16, instruction word) and `Flags` (4, {Z,C,N,O} from ALU).
REQ-004 SHALL drive outputs RF_OutASel 3, RF_OutBSel 3, RF_FunSel 3, RF_RegSel 4, RF_ScrSel 4, ALU_FunSel 5, ALU_WF 1, ARF_OutCSel 2, ARF_OutDSel 2, ARF_FunSel 2, ARF_RegSel 3, IR_LH 1, IR_Write 1, Mem_WR 1, Mem_CS 1, MuxASel 2, MuxBSel 2, MuxCSel 2, DR_FunSel 2, DR_E 1, MuxDSel 1.
REQ-005 SHALL drive outputs `T` (3, sequence counter) and `Halted` (1, high in HALT).

Function
REQ-006 SHALL be a Moore FSM with states FETCH_L, FETCH_H, EXEC1, EXEC2, HALT; T = 0, 1, 2, 3, 7 respectively.
REQ-007 SHALL define IDLE outputs: all RegSel/ScrSel = none; IR_Write, DR_E, ALU_WF, Mem_WR = 0; Mem_CS = 1 (deselected); selects = 0.
REQ-008 SHALL, in FETCH_L, drive ARF_OutDSel=PC, Mem_CS=0, Mem_WR=0, IR_Write=1, IR_LH=0, ARF_RegSel=PC, ARF_FunSel=INC; next FETCH_H.
REQ-009 SHALL, in FETCH_H, drive the same with IR_LH=1; next EXEC1.
REQ-010 SHALL decode `IROut` in EXEC1: op=[15:12], Rd=[11:10] (R1..R4), Rs=[9:8], imm=[7:0].
REQ-011 SHALL execute op 0 (NOP) as IDLE, then go to FETCH_L.
REQ-012 SHALL execute op 1 (BRA) with MuxBSel=IR, ARF_RegSel=PC, ARF_FunSel=LOAD, then go to FETCH_L.
REQ-013 SHALL execute op 2 (MOVI) with MuxASel=IR, RF_RegSel=Rd, RF_FunSel=LOAD, then go to FETCH_L.
REQ-014 SHALL execute ops 3/4/5 (ADD/SUB/AND) with OutASel=Rd, OutBSel=Rs, MuxDSel=0, ALU_FunSel=ADD/SUB/AND, ALU_WF=1, MuxASel=ALU, RF load Rd; then go to FETCH_L.
REQ-015 SHALL execute op 6 (LD) in two steps:
- EXEC1: OutDSel=AR, Mem_CS=0, DR_E=1, DR_FunSel=LOAD; next EXEC2.
- EXEC2: MuxASel=DR, RF load Rd; then go to FETCH_L.
REQ-016 SHALL execute op 7 (ST) with OutASel=Rd, ALU_FunSel=PASSA, MuxCSel=0, OutDSel=AR, Mem_CS=0, Mem_WR=1; then go to FETCH_L.
REQ-017 SHALL execute op 8 (BEQ) as BRA when Flags[3]=1, otherwise as IDLE; then go to FETCH_L.
REQ-018 SHALL enter HALT on op F and hold IDLE outputs there until Reset.
REQ-019 SHALL treat undefined ops 9–E as NOP.
REQ-020 SHALL drive outputs purely from the registered state and `IROut`; outputs SHALL have no combinational path from `Flags` except in BEQ.

Reset
REQ-021 SHALL, while Reset=1, force state to FETCH_L and drive IDLE outputs with T=0 and Halted=0.
REQ-022 SHALL abort any in-progress instruction when Reset is asserted, with no partial write afterwards.
REQ-023 SHALL perform the first fetch on the first rising edge of Clock after Reset is released.

Structure
REQ-024 SHALL take opcode constants, state enum and control encodings (RF/ARF/ALU/DR/Mux codes, register one-hot selects) from shared package `cpu_pkg`.
REQ-025 SHALL contain one sub-module, `sequence_counter`: 3-bit, with clear and load-7.

Verification
REQ-026 SHALL cover: reset release followed by 2 cycles -> FETCH_L then FETCH_H outputs, T=0 then 1, PC INC asserted both cycles.
REQ-027 SHALL cover: IROut=0x2A5C (MOVI R3,0x5C) at EXEC1 -> MuxASel=IR, RF_RegSel=R3, FunSel=LOAD, then T=0 next cycle.
REQ-028 SHALL cover: IROut=0x6400 (LD R2) -> EXEC1 DR_E=1 and Mem_CS=0, then EXEC2 MuxASel=DR and RF_RegSel=R2; 4 cycles total.
REQ-029 SHALL cover: IROut=0x8010 (BEQ) with Flags=4'b1000 -> PC LOAD; with Flags=0 -> ARF_RegSel=none.
REQ-030 SHALL cover: IROut=0xF000 -> Halted=1, T=7 and IDLE held for 20 cycles; Reset then gives T=0 and Halted=0.
REQ-031 SHALL cover: Reset asserted mid-EXEC1 of ST -> Mem_WR=0 immediately and outputs IDLE.
